change_dispenser: RTL and testbench

- Vending-machine back end: pays out change as a coin sequence once an item price is known.
- Takes latched customer credit and the selected item's price (8-bit cents, from the price lookup) on a start strobe.
- Computes change, or a full refund when credit is short, and drives a coin hopper one coin at a time over a req/ack handshake.
- Sits between the vend controller and the hopper interface.

---
 rtl/vend_pkg.sv | 26 ++
 rtl/change_dispenser_coin_select.sv | 39 +++
 rtl/change_dispenser.sv | 140 ++++++++++++++
 tb/tb_change_dispenser.sv | 234 +++++++++++++++++++++++
 4 files changed

// File: rtl/vend_pkg.sv
// Shared definitions for the change dispenser: coin values, coin_type
// encoding and the payout FSM states.
package vend_pkg;

   localparam logic [6:0] NICKEL_C  = 7'd5;
   localparam logic [6:0] DIME_C    = 7'd10;
   localparam logic [6:0] QUARTER_C = 7'd25;
   localparam logic [6:0] DOLLAR_C  = 7'd100;

   typedef enum logic [1:0] {
      COIN_NICKEL  = 2'd0,
      COIN_DIME    = 2'd1,
      COIN_QUARTER = 2'd2,
      COIN_DOLLAR  = 2'd3
   } coin_t;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_CHECK,
      ST_REQ,
      ST_GAP,
      ST_DONE,
      ST_FAULT
   } state_t;

endpackage

// File: rtl/change_dispenser_coin_select.sv
// Greedy coin picker: largest coin not exceeding the remaining change.
// DOLLAR_COIN_EN adds the dollar coin at the head of the chain.
module coin_select
   import vend_pkg::*;
(
   input  logic [7:0] remaining,
   output logic [1:0] coin_type,
   output logic [6:0] value,
   output logic       has_coin
);

   // Pick the largest payable coin for the current remaining amount.
   always_comb begin
      coin_type = COIN_NICKEL;
      value     = NICKEL_C;
      has_coin  = (remaining >= {1'b0, NICKEL_C});
`ifdef DOLLAR_COIN_EN
      if (remaining >= {1'b0, DOLLAR_C}) begin
         coin_type = COIN_DOLLAR;
         value     = DOLLAR_C;
      end else if (remaining >= {1'b0, QUARTER_C}) begin
         coin_type = COIN_QUARTER;
         value     = QUARTER_C;
      end else if (remaining >= {1'b0, DIME_C}) begin
         coin_type = COIN_DIME;
         value     = DIME_C;
      end
`else
      if (remaining >= {1'b0, QUARTER_C}) begin
         coin_type = COIN_QUARTER;
         value     = QUARTER_C;
      end else if (remaining >= {1'b0, DIME_C}) begin
         coin_type = COIN_DIME;
         value     = DIME_C;
      end
`endif
   end

endmodule

// File: rtl/change_dispenser.sv
// Change dispenser: computes change (or a full refund when credit is short)
// and pays it out one coin at a time over a req/ack hopper handshake.
// Optional macro DOLLAR_COIN_EN enables the dollar coin (see coin_select).
module change_dispenser
   import vend_pkg::*;
#(
   parameter int unsigned GAP_CYCLES  = 4,
   parameter int unsigned ACK_TIMEOUT = 1000
)(
   input  logic       clk,
   input  logic       rst_n,
   input  logic       start,
   input  logic [7:0] credit,
   input  logic [7:0] cost,
   output logic       coin_req,
   output logic [1:0] coin_type,
   input  logic       coin_ack,
   output logic       busy,
   output logic       done,
   output logic       refund,
   output logic [2:0] residual,
   output logic       fault
);

   localparam int unsigned TW = $clog2(ACK_TIMEOUT + 1);
   localparam int unsigned GW = $clog2(GAP_CYCLES + 1);
   localparam logic [TW-1:0] T_LAST = TW'(ACK_TIMEOUT - 1);
   localparam logic [GW-1:0] G_LAST = GW'(GAP_CYCLES - 1);

   state_t        state, next;
   logic [7:0]    credit_q, cost_q, remaining, rem_calc, sel_in;
   logic [6:0]    val_q, sel_val;
   logic [1:0]    sel_type;
   logic          sel_has;
   logic [TW-1:0] tcnt;
   logic [GW-1:0] gcnt;

   assign rem_calc = (credit_q >= cost_q) ? (credit_q - cost_q) : credit_q;
   // The coin for REQ entry is chosen from the freshly computed change when
   // leaving CHECK, and from the running remainder when leaving GAP.
   assign sel_in = (state == ST_CHECK) ? rem_calc : remaining;

   coin_select u_sel (
      .remaining (sel_in),
      .coin_type (sel_type),
      .value     (sel_val),
      .has_coin  (sel_has)
   );

   // State register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= ST_IDLE;
      else        state <= next;
   end

   // Next-state decode and state-derived outputs.
   always_comb begin
      next     = state;
      coin_req = 1'b0;
      busy     = 1'b1;
      done     = 1'b0;
      fault    = 1'b0;
      case (state)
         ST_IDLE: begin
            busy = 1'b0;
            if (start) next = ST_CHECK;
         end
         ST_CHECK: next = sel_has ? ST_REQ : ST_DONE;
         ST_REQ: begin
            coin_req = 1'b1;
            if (coin_ack)           next = ST_GAP;
            else if (tcnt == T_LAST) next = ST_FAULT;
         end
         ST_GAP: if (gcnt == G_LAST) next = sel_has ? ST_REQ : ST_DONE;
         ST_DONE: begin
            done = 1'b1;
            next = ST_IDLE;
         end
         ST_FAULT: fault = 1'b1;
         default: next = ST_IDLE;
      endcase
   end

   // Datapath: latch inputs, track remaining change, coin and cycle counters.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         credit_q  <= '0;
         cost_q    <= '0;
         remaining <= '0;
         val_q     <= '0;
         coin_type <= '0;
         refund    <= 1'b0;
         residual  <= '0;
         tcnt      <= '0;
         gcnt      <= '0;
      end else begin
         case (state)
            ST_IDLE: if (start) begin
               credit_q <= credit;
               cost_q   <= cost;
               refund   <= (credit < cost);
               residual <= '0;
            end
            ST_CHECK: begin
               remaining <= rem_calc;
               if (sel_has) begin
                  coin_type <= sel_type;
                  val_q     <= sel_val;
                  tcnt      <= '0;
               end else begin
                  residual <= rem_calc[2:0];
               end
            end
            ST_REQ: begin
               if (coin_ack) begin
                  remaining <= remaining - {1'b0, val_q};
                  gcnt      <= '0;
               end else begin
                  tcnt <= tcnt + 1'b1;
               end
            end
            ST_GAP: begin
               if (gcnt == G_LAST) begin
                  if (sel_has) begin
                     coin_type <= sel_type;
                     val_q     <= sel_val;
                     tcnt      <= '0;
                  end else begin
                     residual <= remaining[2:0];
                  end
               end else begin
                  gcnt <= gcnt + 1'b1;
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_change_dispenser.sv
// Self-checking bench for change_dispenser: directed table, random payouts
// against an arithmetic change model, hopper timeout and async reset cases.
module tb_change_dispenser;

   localparam int GAP = 3;
   localparam int TO  = 20;

   logic       clk = 1'b0;
   logic       rst_n, start, coin_ack, coin_req, busy, done, refund, fault;
   logic [7:0] credit, cost;
   logic [1:0] coin_type;
   logic [2:0] residual;

   int tests = 0;
   int fails = 0;

   always #5 clk = ~clk;

   change_dispenser #(.GAP_CYCLES(GAP), .ACK_TIMEOUT(TO)) dut (
      .clk(clk), .rst_n(rst_n), .start(start), .credit(credit), .cost(cost),
      .coin_req(coin_req), .coin_type(coin_type), .coin_ack(coin_ack),
      .busy(busy), .done(done), .refund(refund), .residual(residual),
      .fault(fault)
   );

   task automatic chk(input string name, input int act, input int exp);
      tests++;
      if (act != exp) begin
         fails++;
         $display("FAIL %s: got %0d, expected %0d", name, act, exp);
      end
   endtask

   // Reference: change amount split into denominations by division.
   int exp_q[$];
   int exp_res;
   int exp_ref;
   function automatic void model(input int cr, input int co);
      int rem, n;
      int vals[$];
      int types[$];
`ifdef DOLLAR_COIN_EN
      vals = '{100, 25, 10, 5};
      types = '{3, 2, 1, 0};
`else
      vals = '{25, 10, 5};
      types = '{2, 1, 0};
`endif
      exp_ref = (cr < co) ? 1 : 0;
      rem = (cr >= co) ? cr - co : cr;
      exp_q.delete();
      foreach (vals[i]) begin
         n = rem / vals[i];
         for (int k = 0; k < n; k++) exp_q.push_back(types[i]);
         rem = rem % vals[i];
      end
      exp_res = rem;
   endfunction

   int got_q[$];
   int gap_q[$];

   // One complete payout with a hopper that acks d cycles after coin_req rises.
   task automatic payout(input string tag, input int cr, input int co, input int d,
                         input bit second, input int tn, input int tres, input int tref);
      int cyc, low_run, req_len, first_req, done_cyc, nmin;
      bit req_prev, stable_ok;
      logic [1:0] cur_type;
      got_q.delete();
      gap_q.delete();
      model(cr, co);
      @(negedge clk);
      start = 1'b1; credit = cr[7:0]; cost = co[7:0];
      @(negedge clk);
      start = 1'b0; credit = '0; cost = '0;
      chk({tag, " refund_in_check"}, int'(refund), exp_ref);
      chk({tag, " busy_in_check"}, int'(busy), 1);
      cyc = 1; low_run = 0; req_len = 0; req_prev = 1'b0;
      first_req = -1; done_cyc = -1; stable_ok = 1'b1; cur_type = '0;
      while (done_cyc < 0 && cyc < 2000) begin
         @(negedge clk);
         cyc++;
         start = second && (cyc == 5);
         if (start) begin credit = 8'd60; cost = 8'd0; end
         if (coin_req) begin
            if (!req_prev) begin
               if (first_req < 0) first_req = cyc;
               else gap_q.push_back(low_run);
               got_q.push_back(int'(coin_type));
               cur_type = coin_type;
               req_len = 0;
               low_run = 0;
            end else if (coin_type != cur_type) begin
               stable_ok = 1'b0;
            end
            req_len++;
            coin_ack = (req_len == d + 1);
         end else begin
            coin_ack = 1'b0;
            low_run++;
         end
         req_prev = coin_req;
         if (done) done_cyc = cyc;
      end
      chk({tag, " done_within_bound"}, (done_cyc > 0) ? 1 : 0, 1);
      if (done_cyc > 0) begin
         chk({tag, " residual"}, int'(residual), exp_res);
         chk({tag, " refund_at_done"}, int'(refund), exp_ref);
         chk({tag, " coin_count"}, got_q.size(), exp_q.size());
         nmin = (got_q.size() < exp_q.size()) ? got_q.size() : exp_q.size();
         for (int i = 0; i < nmin; i++)
            chk($sformatf("%s coin_type[%0d]", tag, i), got_q[i], exp_q[i]);
         foreach (gap_q[i])
            chk($sformatf("%s gap[%0d]", tag, i), gap_q[i], GAP);
         chk({tag, " type_stable"}, int'(stable_ok), 1);
         if (exp_q.size() > 0) chk({tag, " first_req_latency"}, first_req, 2);
         else                  chk({tag, " done_latency"}, done_cyc, 2);
         if (tn >= 0) begin
            chk({tag, " table_coins"}, got_q.size(), tn);
            chk({tag, " table_residual"}, int'(residual), tres);
            chk({tag, " table_refund"}, int'(refund), tref);
         end
         @(negedge clk);
         coin_ack = 1'b0;
         chk({tag, " done_one_cycle"}, int'(done), 0);
         chk({tag, " idle_after_done"}, int'(busy), 0);
      end
   endtask

   task automatic wait_req(input string tag);
      int n;
      n = 0;
      while (!coin_req && n < 10) begin @(negedge clk); n++; end
      chk({tag, " req_seen"}, int'(coin_req), 1);
   endtask

   task automatic chk_all_zero(input string tag);
      chk({tag, " coin_req"}, int'(coin_req), 0);
      chk({tag, " busy"}, int'(busy), 0);
      chk({tag, " done"}, int'(done), 0);
      chk({tag, " refund"}, int'(refund), 0);
      chk({tag, " residual"}, int'(residual), 0);
      chk({tag, " fault"}, int'(fault), 0);
      chk({tag, " coin_type"}, int'(coin_type), 0);
   endtask

   typedef struct {
      int cr; int co; int d; bit second; int n; int res; int rf;
   } vec_t;
   vec_t vecs[$];

   initial begin
      int cr, co, d, cnt;
      rst_n = 1'b0; start = 1'b0; coin_ack = 1'b0; credit = '0; cost = '0;
      #12;
      chk_all_zero("reset");
      @(negedge clk);
      rst_n = 1'b1;

`ifdef DOLLAR_COIN_EN
      vecs.push_back('{200, 125, 1, 1'b0, 3, 0, 0});
      vecs.push_back('{255, 85, 1, 1'b0, 5, 0, 0});
      vecs.push_back('{100, 150, 1, 1'b1, 1, 0, 1});
      vecs.push_back('{137, 100, 0, 1'b0, 2, 2, 0});
      vecs.push_back('{130, 130, 0, 1'b0, 0, 0, 0});
      vecs.push_back('{255, 0, 0, 1'b0, 5, 0, 0});
`else
      vecs.push_back('{200, 125, 1, 1'b0, 3, 0, 0});
      vecs.push_back('{255, 85, 1, 1'b0, 8, 0, 0});
      vecs.push_back('{100, 150, 1, 1'b1, 4, 0, 1});
      vecs.push_back('{137, 100, 0, 1'b0, 2, 2, 0});
      vecs.push_back('{130, 130, 0, 1'b0, 0, 0, 0});
      vecs.push_back('{255, 0, 0, 1'b0, 11, 0, 0});
`endif
      vecs.push_back('{3, 0, 0, 1'b0, 0, 3, 0});
      vecs.push_back('{4, 200, 2, 1'b0, 0, 4, 1});
      vecs.push_back('{9, 2, 2, 1'b0, 1, 2, 0});

      foreach (vecs[i])
         payout($sformatf("vec%0d", i), vecs[i].cr, vecs[i].co, vecs[i].d,
                vecs[i].second, vecs[i].n, vecs[i].res, vecs[i].rf);

      for (int i = 0; i < 25; i++) begin
         cr = int'($urandom_range(0, 255));
         co = ($urandom_range(0, 1) == 1) ? int'($urandom_range(0, cr)) : int'($urandom_range(0, 255));
         d  = int'($urandom_range(0, 3));
         payout($sformatf("rnd%0d", i), cr, co, d, 1'b0, -1, 0, 0);
      end

      // Hopper never acks: fault after exactly TO request cycles, sticky.
      @(negedge clk);
      start = 1'b1; credit = 8'd50; cost = 8'd0;
      @(negedge clk);
      start = 1'b0;
      wait_req("timeout");
      cnt = 0;
      while (coin_req && cnt < TO + 10) begin cnt++; @(negedge clk); end
      chk("timeout req_cycles", cnt, TO);
      chk("timeout fault", int'(fault), 1);
      chk("timeout busy", int'(busy), 1);
      chk("timeout coin_req", int'(coin_req), 0);
      coin_ack = 1'b1; start = 1'b1;
      repeat (3) @(negedge clk);
      coin_ack = 1'b0; start = 1'b0;
      repeat (5) @(negedge clk);
      chk("fault sticky", int'(fault), 1);
      chk("fault no_req", int'(coin_req), 0);
      rst_n = 1'b0;
      #1;
      chk_all_zero("fault_reset");
      @(negedge clk);
      rst_n = 1'b1;

      // Reset in the middle of a refund payout clears everything at once.
      @(negedge clk);
      start = 1'b1; credit = 8'd50; cost = 8'd100;
      @(negedge clk);
      start = 1'b0;
      wait_req("midreq");
      #2;
      rst_n = 1'b0;
      #1;
      chk_all_zero("midreq_reset");
      @(negedge clk);
      rst_n = 1'b1;
      cnt = 0;
      repeat (10) begin @(negedge clk); if (coin_req) cnt++; end
      chk("midreq no_more_coins", cnt, 0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
